// File: rtl/nf_chi_pkg.sv
// Shared constants, types and the component index map for the masked chi row
// compressor.
package nf_chi_pkg;

  localparam int unsigned N_SHARES       = 3;
  localparam int unsigned ROW_W          = 5;
  localparam int unsigned COMP_PER_SHARE = 3;
  localparam int unsigned N_COMP         = ROW_W * N_SHARES * COMP_PER_SHARE;

  // One row worth of output shares; index [s-1][g]
  typedef logic [N_SHARES-1:0][ROW_W-1:0] shares_t;

  // Position of component k of share s (1-based) for output bit g
  function automatic int unsigned comp_idx(input int unsigned g,
                                           input int unsigned s,
                                           input int unsigned k);
    return g * (N_SHARES * COMP_PER_SHARE) + (s - 1) * COMP_PER_SHARE + k;
  endfunction

endpackage

// File: rtl/nf_share_compress.sv
// Purely combinational 45->15 XOR compressor: each output share bit is the
// XOR of its three coordinate-function components.
module nf_share_compress
  import nf_chi_pkg::*;
(
  input  logic [N_COMP-1:0] comp,
  output shares_t           shares
);

  for (genvar g = 0; g < ROW_W; g++) begin : g_bit
    for (genvar s = 0; s < N_SHARES; s++) begin : g_share
      assign shares[s][g] = ^comp[comp_idx(g, s + 1, 0) +: COMP_PER_SHARE];
    end
  end

endmodule

// File: rtl/nf_chi_compress.sv
// Receiving end of the null-fresh masked chi row datapath. Stage 1 registers
// the 45 component bits as a glitch barrier; stage 2 holds the compressed
// shares and the end-of-pass tag.
// Optional: define NF_CHI_UNMASK_DEBUG_EN to add the dbg_plain port
// (unmasked row, simulation only; never build leakage netlists with it).
module nf_chi_compress
  import nf_chi_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 320,
  parameter int unsigned CNT_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_COMP-1:0] comp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  share1,
  output logic [ROW_W-1:0]  share2,
  output logic [ROW_W-1:0]  share3,
  output logic              out_last
`ifdef NF_CHI_UNMASK_DEBUG_EN
  ,
  output logic [ROW_W-1:0]  dbg_plain
`endif
);

  logic [N_COMP-1:0] c1;
  logic              v1;
  logic              last1;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_at_last;
  shares_t           sh_c;
  shares_t           sh2;
  logic              v2;
  logic              last2;
  logic              load1;
  logic              load2;

  assign in_ready    = !v1 || !v2 || out_ready;
  assign load2       = v1 && (!v2 || out_ready);
  assign load1       = in_valid && in_ready;
  assign cnt_at_last = (cnt == CNT_W'(NUM_ROWS - 1));

  // Stage 1: glitch barrier for the raw components plus the row tag
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      c1    <= '0;
      last1 <= 1'b0;
    end else begin
      if (load1) begin
        c1    <= comp;
        last1 <= cnt_at_last;
      end
      if (load1)      v1 <= 1'b1;
      else if (load2) v1 <= 1'b0;
    end
  end

  // Row counter framing one state pass; advances on every stage-1 load
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= cnt_at_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Compression reads only the stage-1 register
  nf_share_compress u_compress (
    .comp   (c1),
    .shares (sh_c)
  );

  // Stage 2: compressed shares and tag, drive the outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      sh2   <= '0;
      last2 <= 1'b0;
    end else if (load2) begin
      v2    <= 1'b1;
      sh2   <= sh_c;
      last2 <= last1;
    end else if (out_ready) begin
      v2    <= 1'b0;
    end
  end

  assign out_valid = v2;
  assign share1    = sh2[0];
  assign share2    = sh2[1];
  assign share3    = sh2[2];
  assign out_last  = last2;

`ifdef NF_CHI_UNMASK_DEBUG_EN
  assign dbg_plain = sh2[0] ^ sh2[1] ^ sh2[2];
`endif

endmodule

// File: tb/tb_nf_chi_compress.sv
// Randomized, self-checking bench for nf_chi_compress with a queue-based
// reference model of the two-row pipeline and row framing.
module tb_nf_chi_compress;

  localparam int NUM_ROWS = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [44:0] comp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  share1, share2, share3;
  logic        out_last;
`ifdef NF_CHI_UNMASK_DEBUG_EN
  logic [4:0]  dbg_plain;
`endif

  nf_chi_compress #(.NUM_ROWS(320), .CNT_W(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .comp      (comp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .share1    (share1),
    .share2    (share2),
    .share3    (share3),
    .out_last  (out_last)
`ifdef NF_CHI_UNMASK_DEBUG_EN
    ,
    .dbg_plain (dbg_plain)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] sh;
    logic        last;
    logic [4:0]  chi;
    logic        has_chi;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          row_cnt = 0;
  int          acc_total = 0;
  int          out_since_rst = 0;
  int          last_count = 0;
  int          last_idx = -1;
  logic [4:0]  cur_chi = '0;
  logic        cur_has_chi = 1'b0;
  bit          rst_applied = 0;
  bit          hold = 0;
  logic [14:0] held_sh = '0;
  logic        held_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Plain chi on one 5-bit row
  function automatic logic [4:0] chi(input logic [4:0] x);
    logic [4:0] y;
    for (int i = 0; i < 5; i++)
      y[i] = x[i] ^ (~x[3'((i + 1) % 5)] & x[3'((i + 2) % 5)]);
    return y;
  endfunction

  // Reference compression: component n feeds share (n%9)/3, bit n/9.
  // Result packed as {share3, share2, share1}.
  function automatic logic [14:0] ref_compress(input logic [44:0] c);
    logic [14:0] r = '0;
    for (int n = 0; n < 45; n++)
      r[4'(((n % 9) / 3) * 5 + n / 9)] ^= c[6'(n)];
    return r;
  endfunction

  // Random 3-share masking of row y, each share bit split into 3 components
  function automatic logic [44:0] mask_row(input logic [4:0] y);
    logic [44:0] c = '0;
    logic [2:0]  sb;
    logic [1:0]  r;
    for (int g = 0; g < 5; g++) begin
      sb    = 3'($urandom);
      sb[2] = y[g] ^ sb[0] ^ sb[1];
      for (int s = 0; s < 3; s++) begin
        r = 2'($urandom);
        c[6'(9 * g + 3 * s)]     = r[0];
        c[6'(9 * g + 3 * s + 1)] = r[1];
        c[6'(9 * g + 3 * s + 2)] = sb[s] ^ r[0] ^ r[1];
      end
    end
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: model occupancy, latency, data, tags, stability
  always @(negedge clk) begin : mon
    logic [14:0] dut_sh;
    exp_t        e;
    bit          exp_valid;
    dut_sh = {share3, share2, share1};
    if (rst_applied) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_shares", dut_sh, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    if (rst) begin
      q.delete();
      row_cnt       = 0;
      rst_applied   = 1;
      hold          = 0;
      out_since_rst = 0;
      last_count    = 0;
      last_idx      = -1;
    end else begin
      rst_applied = 0;
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      exp_valid = (q.size() > 0) && (q[0].acc < cyc);
      chk("out_valid", out_valid, exp_valid);
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_last, dut_sh}, {held_last, held_sh});
      end
      if (out_valid && q.size() > 0) begin
        e = q[0];
        chk("shares", dut_sh, e.sh);
        chk("out_last", out_last, e.last);
        if (e.has_chi) begin
          chk("plain_chi", share1 ^ share2 ^ share3, e.chi);
`ifdef NF_CHI_UNMASK_DEBUG_EN
          chk("dbg_plain", dbg_plain, e.chi);
`endif
        end
      end
      hold      = out_valid && !out_ready;
      held_sh   = dut_sh;
      held_last = out_last;
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        if (out_last) begin
          last_count++;
          last_idx = out_since_rst;
        end
        out_since_rst++;
      end
      if (in_valid && in_ready) begin
        e.sh      = ref_compress(comp);
        e.last    = (row_cnt == NUM_ROWS - 1);
        e.chi     = cur_chi;
        e.has_chi = cur_has_chi;
        e.acc     = cyc + 1;
        q.push_back(e);
        row_cnt = (row_cnt + 1) % NUM_ROWS;
        acc_total++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input bit valid, input bit masked);
    logic [4:0] x;
    if (masked) begin
      x           = 5'($urandom);
      cur_chi     = chi(x);
      cur_has_chi = 1'b1;
      comp        = mask_row(cur_chi);
    end else begin
      cur_chi     = '0;
      cur_has_chi = 1'b0;
      comp        = 45'({$urandom(), $urandom()});
    end
    in_valid = valid;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin : stim
    int a0;
    // Literal pins of the reference functions
    chk("pin_comp_n0", ref_compress(45'h1), 15'h0001);
    chk("pin_comp_n3", ref_compress(45'h8), 15'h0020);
    chk("pin_comp_n9", ref_compress(45'h200), 15'h0002);
    chk("pin_comp_n44", ref_compress(45'h1 << 44), 15'h4000);
    chk("pin_chi_04", chi(5'h04), 5'h05);
    chk("pin_chi_01", chi(5'h01), 5'h09);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Single row, only component 0 set
    comp = 45'h1; cur_has_chi = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_share1", share1, 5'b00001);
    chk("single_share2", share2, 5'b00000);
    chk("single_share3", share3, 5'b00000);
    chk("single_last", out_last, 0);
    tick();

    // One-hot sweep over all components
    cur_has_chi = 1'b0;
    for (int n = 0; n < 45; n++) begin
      comp = 45'h1 << n;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure
    repeat (1500) begin
      out_ready = ($urandom % 3) != 0;
      drive_row(($urandom % 4) != 0, ($urandom % 2) != 0);
      tick();
    end

    // Fill the pipe, then reset mid-pass
    out_ready = 1'b0;
    drive_row(1, 1);
    repeat (3) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // Full pass plus a few rows, back to back
    repeat (330) begin
      drive_row(1, 1);
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("pass_last_count", last_count, 1);
    chk("pass_last_idx", last_idx, NUM_ROWS - 1);

    // Directed backpressure: only two rows fit
    out_ready = 1'b0;
    a0 = acc_total;
    repeat (5) begin
      drive_row(1, 1);
      tick();
    end
    chk("bp_accepts", acc_total - a0, 2);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
